// File: rtl/cond_issue_stage.sv
// Single-entry issue stage. Evaluates the condition code against forwarded
// flags and holds back dependent instructions while flag writes are in flight.
module cond_issue_stage #(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned PEND_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_exec,
  input  logic               flag_we,
  input  logic [3:0]         flags_in,
  output logic [3:0]         flags_q
);

  localparam int unsigned CNT_W   = $clog2(PEND_MAX + 1);
  localparam logic [3:0]  COND_AL = 4'hE;
  localparam logic [3:0]  COND_NV = 4'hF;

  logic               full;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   pend_cnt;
  logic [3:0]         cond;
  logic               s_bit;
  logic [3:0]         fe;
  logic               fn, fz, fc, fv;
  logic               cond_pass;
  logic               blk_cond;
  logic               blk_full;
  logic               in_hs;
  logic               out_hs;
  logic               pend_inc;
  logic               pend_dec;

  assign cond  = instr_q[31:28];
  assign s_bit = instr_q[23];

  // Same-cycle forwarding of the ALU flag writeback.
  assign fe = flag_we ? flags_in : flags_q;
  assign {fn, fz, fc, fv} = fe;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // A flag write arriving with one outstanding producer makes the forwarded flags final.
  assign blk_cond = (cond != COND_AL) && (cond != COND_NV) && (pend_cnt != '0)
                    && !(flag_we && (pend_cnt == CNT_W'(1)));
  assign blk_full = s_bit && (pend_cnt == CNT_W'(PEND_MAX));

  assign out_valid = full && !blk_cond && !blk_full;
  assign out_exec  = full && cond_pass;
  assign out_instr = instr_q;
  assign in_ready  = !full || (out_valid && out_ready);

  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign pend_inc = out_hs && s_bit && out_exec;
  assign pend_dec = flag_we && (pend_cnt != '0);

  // Stage register; a new capture overrides the drain of the issuing entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      instr_q <= '0;
    end else if (in_hs) begin
      full    <= 1'b1;
      instr_q <= in_instr;
    end else if (out_hs) begin
      full    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= flags_in;
    end
  end

  // Outstanding flag-setting instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= '0;
    end else if (pend_inc && !pend_dec) begin
      pend_cnt <= pend_cnt + CNT_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pend_cnt <= pend_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_issue_stage.sv
// Directed bench for cond_issue_stage: condition table, pending-write
// interlock, stall stability and asynchronous reset.
module tb_cond_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_exec;
  logic        flag_we;
  logic [3:0]  flags_in;
  logic [3:0]  flags_q;

  int n_checks = 0;
  int n_fail   = 0;

  cond_issue_stage #(.INSTR_W(32), .PEND_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_exec(out_exec),
    .flag_we(flag_we), .flags_in(flags_in), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs may be changed afterwards and are settled before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] c, input logic s);
    return {c, 4'h2, s, 23'h00_1234};
  endfunction

  logic [15:0] exp_tab;
  logic [31:0] hold;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    flag_we = 1'b0; flags_in = 4'b0000;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", flags_q, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_exec", out_exec, 0);
    tick();
    rst = 1'b0;

    // AL instruction: issue one cycle after capture
    in_valid = 1'b1; in_instr = mk(4'hE, 1'b0);
    #1 check("al_no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("al_valid", out_valid, 1);
    check("al_exec", out_exec, 1);
    check("al_instr", out_instr, mk(4'hE, 1'b0));
    check("al_flags", flags_q, 0);
    tick();
    check("al_drained", out_valid, 0);

    // Z=1: EQ passes, NE fails but still issues
    flag_we = 1'b1; flags_in = 4'b0100;
    tick();
    flag_we = 1'b0;
    check("z_flags", flags_q, 4'b0100);
    in_valid = 1'b1; in_instr = mk(4'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("eq_valid", out_valid, 1);
    check("eq_exec", out_exec, 1);
    tick();
    in_valid = 1'b1; in_instr = mk(4'h1, 1'b0);
    tick();
    in_valid = 1'b0;
    check("ne_valid", out_valid, 1);
    check("ne_exec", out_exec, 0);
    tick();
    check("ne_pend", dut.pend_cnt, 0);
    check("ne_drained", out_valid, 0);

    // SUB s=1 then dependent EQ waits for the flag write
    in_valid = 1'b1; in_instr = mk(4'hE, 1'b1);
    tick();
    in_instr = mk(4'h0, 1'b0);
    check("sub_valid", out_valid, 1);
    tick();
    in_valid = 1'b0;
    check("sub_pend", dut.pend_cnt, 1);
    check("dep_blocked", out_valid, 0);
    tick();
    check("dep_blocked2", out_valid, 0);
    flag_we = 1'b1; flags_in = 4'b0100;
    #1;
    check("dep_fwd_valid", out_valid, 1);
    check("dep_fwd_exec", out_exec, 1);
    tick();
    flag_we = 1'b0;
    check("dep_pend0", dut.pend_cnt, 0);
    check("dep_drained", out_valid, 0);

    // Saturate pending counter with s=1 AL issues
    in_valid = 1'b1; in_instr = mk(4'hE, 1'b1);
    repeat (4) tick();
    in_valid = 1'b0;
    check("sat_pend", dut.pend_cnt, 3);
    check("sat_blocked", out_valid, 0);
    check("sat_in_ready", in_ready, 0);
    flag_we = 1'b1; flags_in = 4'b0000;
    #1 check("sat_blocked_we", out_valid, 0);
    tick();
    flag_we = 1'b0;
    check("sat_pend2", dut.pend_cnt, 2);
    check("sat_issue", out_valid, 1);
    tick();
    check("sat_pend3", dut.pend_cnt, 3);
    flag_we = 1'b1;
    tick();
    tick();
    flag_we = 1'b0;
    check("drain_pend1", dut.pend_cnt, 1);

    // Issue with s=1 and flag_we in the same cycle at pend_cnt=1
    in_valid = 1'b1; in_instr = mk(4'hE, 1'b1);
    tick();
    in_valid = 1'b0;
    flag_we = 1'b1; flags_in = 4'b1010;
    #1 check("same_valid", out_valid, 1);
    tick();
    check("same_pend", dut.pend_cnt, 1);
    check("same_flags", flags_q, 4'b1010);
    tick();
    flag_we = 1'b0;
    check("same_pend0", dut.pend_cnt, 0);

    // Full condition table, flags N=1 C=1
    exp_tab = 16'h6996;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1; in_instr = mk(4'(c), 1'b0);
      tick();
      in_valid = 1'b0;
      check($sformatf("tab_a_%0h", c), out_exec, exp_tab[c]);
      tick();
    end
    // Flags V=1 only
    flag_we = 1'b1; flags_in = 4'b0001;
    tick();
    flag_we = 1'b0;
    exp_tab = 16'h6A6A;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1; in_instr = mk(4'(c), 1'b0);
      tick();
      in_valid = 1'b0;
      check($sformatf("tab_b_%0h", c), out_exec, exp_tab[c]);
      tick();
    end

    // Leave one write pending, then stall and reset mid-stall
    in_valid = 1'b1; in_instr = mk(4'hE, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_stall_pend", dut.pend_cnt, 1);
    hold = 32'hE123_4567;
    in_valid = 1'b1; in_instr = hold; out_ready = 1'b0;
    tick();
    in_instr = mk(4'hE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_valid_%0d", i), out_valid, 1);
      check($sformatf("stall_instr_%0d", i), out_instr, hold);
      check($sformatf("stall_in_ready_%0d", i), in_ready, 0);
      tick();
    end
    rst = 1'b1; flag_we = 1'b1; flags_in = 4'b1111;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_flags", flags_q, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_pend", dut.pend_cnt, 0);
    tick();
    check("rst_ignores_we", flags_q, 0);
    rst = 1'b0; flag_we = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(4'hE, 1'b0);
    tick();
    in_valid = 1'b0;
    check("post_rst_capture", out_valid, 1);
    check("post_rst_instr", out_instr, mk(4'hE, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
